cpu_program_loader: RTL and testbench
=====================================

// Module: cpu_program_loader
// PURPOSE
//  Sits upstream of the cpu top. Receives a byte stream carrying a length-prefixed
//  program image and writes it into the cpu unified memory at addresses 0..N-1.
//  Then pulses the cpu start input once and counts retired instructions via the
//  cpu ready output, reporting done or error. Replaces hierarchical memory pokes
//  with a synthesizable boot path.
// PARAMETERS
//  ADDR_W      9     memory word-address width
//  DATA_W      16    instruction/data word width (fixed 16; two bytes per word)
//  MAX_WORDS   256   largest accepted program length N
//  TIMEOUT_CYC 1024  max cycles allowed between consecutive ready rising edges
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  reset      in   1        asynchronous, active-low reset
//  clear      in   1        sync; leaves DONE/ERR and returns to IDLE
//  in_valid   in   1        byte-stream valid
//  in_data    in   8        byte-stream data
//  in_ready   out  1        byte accepted when in_valid & in_ready
//  mem_we     out  1        one-cycle memory write strobe
//  mem_addr   out  ADDR_W   write address
//  mem_wdata  out  DATA_W   write data
//  cpu_start  out  1        one-cycle start pulse to cpu
//  cpu_ready  in   1        cpu per-instruction ready (level; rising edge = retire)
//  busy       out  1        high from first accepted byte until DONE/ERR
//  done       out  1        sticky success flag
//  error      out  1        sticky failure flag
//  err_code   out  2        01 bad length, 10 timeout, 11 checksum
//  retired    out  ADDR_W+1 count of ready rising edges since cpu_start
// BEHAVIOUR
//  Reset (reset low, async): state IDLE; all outputs 0; counters 0; ready edge reg 0.
//  Stream format: LEN_HI, LEN_LO, then N words as HI byte, LO byte (big-endian).
//  States: IDLE->LEN_HI (same as IDLE; first byte taken)->LEN_LO->chk len->DAT_HI->DAT_LO
//   ->WRITE->(DAT_HI | CSUM | START)->RUN->DONE; any failure ->ERR.
//  in_ready = 1 only in IDLE/LEN_HI/LEN_LO/DAT_HI/DAT_LO/CSUM; 0 elsewhere.
//  Gaps in in_valid stall the FSM without state change.
//  Length check on LEN_LO accept: N==0 or N>MAX_WORDS -> ERR, err_code=01, no writes.
//  WRITE: exactly one cycle, mem_we=1, mem_addr=word index k, mem_wdata={hi,lo}.
//  Addresses 0..N-1 in order; mem_we is 0 in every other state.
//  After word N-1 is written: START for one cycle (cpu_start=1), retired cleared, then RUN.
//  RUN: sample cpu_ready each cycle; rising edge (prev 0, now 1) increments retired
//   and reloads the timeout counter. retired==N -> DONE next cycle.
//  A ready already high at START counts only after a 0->1 transition.
//  Timeout counter reaches TIMEOUT_CYC with no edge -> ERR, err_code=10.
//  DONE/ERR: sticky; busy=0; retired holds. clear=1 -> IDLE, flags/err_code cleared.
//  clear in other states is ignored. retired saturates at N (extra edges ignored).
//  Reset mid-load or mid-run: immediate return to IDLE; partial memory not rolled back.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: after last WRITE, FSM enters CSUM and accepts one byte.
//   Byte must equal XOR of all preceding stream bytes (incl. length bytes).
//   Match -> START; mismatch -> ERR, err_code=11, no cpu_start.
//  Undefined: no CSUM state; after last WRITE go directly to START; code 11 never produced.
// STRUCTURE
//  Package cpu_loader_pkg: FSM state encoding, ERR_LEN/ERR_TIMEOUT/ERR_CSUM constants.
//  One sub-module loader_retire_monitor: ready edge detect, retired counter, timeout
//   counter; inputs arm/target N, outputs hit and expired.
// TESTING
//  Load the 8-word ADD/SUB/MUL/DIV/STORE/LOAD/ADD/STORE program (N=8), with 3-cycle ready gaps
//   -> 8 writes at addr 0..7 with matching words; one cpu_start; done=1, retired=8.
//  Same stream with random in_valid bubbles -> identical write sequence and result.
//  LEN=0x0000; separately LEN=MAX_WORDS+1 -> error=1, err_code=01, mem_we never high.
//  N=2, cpu_ready held 0 after start -> error=1, err_code=10 at TIMEOUT_CYC cycles.
//  LOADER_CHECKSUM_EN: correct XOR -> done; flipped checksum bit -> err_code=11, no start.
//  Reset low after 3 words written -> all outputs 0 immediately.
//   Reload with N=1 -> done, retired=1.

Source files
------------

// File: rtl/cpu_program_loader_pkg.sv
// rtl/cpu_program_loader_pkg.sv - state encoding and error codes for the cpu program loader
// LOADER_CHECKSUM_EN adds the CSUM state.
package cpu_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_START,
        S_RUN,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_CSUM    = 2'b11;

    // S_IDLE doubles as LEN_HI: the first byte is taken straight from idle.
    function automatic logic takes_byte(loader_state_t s);
        return (s == S_IDLE) || (s == S_LEN_LO) || (s == S_DAT_HI) || (s == S_DAT_LO)
`ifdef LOADER_CHECKSUM_EN
            || (s == S_CSUM)
`endif
            ;
    endfunction

endpackage

// File: rtl/cpu_program_loader_if.sv
// rtl/cpu_program_loader_if.sv - byte stream, memory write and cpu handshake bundle
interface cpu_program_loader_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_start;
    logic              cpu_ready;

    modport master (
        input  in_valid, in_data, cpu_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_start
    );

    modport slave (
        output in_valid, in_data, cpu_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_start
    );
endinterface

// File: rtl/cpu_program_loader_retire_monitor.sv
// rtl/cpu_program_loader_retire_monitor.sv - cpu_ready edge counter with inter-edge timeout
module loader_retire_monitor #(
    parameter int ADDR_W      = 9,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              run,
    input  logic              cpu_ready,
    input  logic [ADDR_W:0]   target,
    output logic [ADDR_W:0]   retired,
    output logic              hit,
    output logic              expired
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TMO_MAX = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0]   T_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] R_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic          ready_q;
    logic [TW-1:0] tmo;
    logic          rise;

    // ready_q tracks cpu_ready every cycle, so a level already high at arm never counts.
    assign rise    = cpu_ready & ~ready_q;
    assign hit     = (retired == target);
    assign expired = (tmo == TMO_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
            retired <= '0;
            tmo     <= '0;
        end else begin
            ready_q <= cpu_ready;
            if (arm) begin
                retired <= '0;
                tmo     <= '0;
            end else if (run) begin
                if (rise) begin
                    tmo <= '0;
                    if (retired != target)
                        retired <= retired + R_ONE;
                end else if (!expired) begin
                    tmo <= tmo + T_ONE;
                end
            end
        end
    end
endmodule

// File: rtl/cpu_program_loader.sv
// rtl/cpu_program_loader.sv - boots a length-prefixed program image into cpu memory, starts the cpu, tracks retirement
// Optional LOADER_CHECKSUM_EN: trailing XOR checksum byte is verified before cpu_start.
module cpu_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 16,
    parameter int MAX_WORDS   = 256,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    cpu_program_loader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [ADDR_W:0]      retired
);
    localparam logic [ADDR_W:0] K_ONE = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t   state;
    logic [7:0]      len_hi;
    logic [7:0]      hi_byte;
    logic [ADDR_W:0] n_words;
    logic [ADDR_W:0] k;
    logic [15:0]     len_word;
    logic            hit;
    logic            expired;

    assign len_word     = {len_hi, bus.in_data};
    assign bus.in_ready = takes_byte(state);
    assign busy         = !(state inside {S_IDLE, S_DONE, S_ERR});

    loader_retire_monitor #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_retire (
        .clk       (clk),
        .reset     (reset),
        .arm       (state == S_START),
        .run       (state == S_RUN),
        .cpu_ready (bus.cpu_ready),
        .target    (n_words),
        .retired   (retired),
        .hit       (hit),
        .expired   (expired)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of every accepted stream byte; restarts with the first length byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            csum <= '0;
        else if (bus.in_valid && state == S_IDLE)
            csum <= bus.in_data;
        else if (bus.in_valid && bus.in_ready && state != S_CSUM)
            csum <= csum ^ bus.in_data;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            len_hi        <= '0;
            hi_byte       <= '0;
            n_words       <= '0;
            k             <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_start <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= ERR_NONE;
        end else begin
            bus.mem_we    <= 1'b0;
            bus.cpu_start <= 1'b0;
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    len_hi <= bus.in_data;
                    state  <= S_LEN_LO;
                end
                S_LEN_LO: if (bus.in_valid) begin
                    if (len_word == 16'd0 || len_word > 16'(MAX_WORDS)) begin
                        error    <= 1'b1;
                        err_code <= ERR_LEN;
                        state    <= S_ERR;
                    end else begin
                        n_words <= len_word[ADDR_W:0];
                        k       <= '0;
                        state   <= S_DAT_HI;
                    end
                end
                S_DAT_HI: if (bus.in_valid) begin
                    hi_byte <= bus.in_data;
                    state   <= S_DAT_LO;
                end
                // Strobe is launched here so mem_we is high for exactly the WRITE cycle.
                S_DAT_LO: if (bus.in_valid) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= k[ADDR_W-1:0];
                    bus.mem_wdata <= DATA_W'({hi_byte, bus.in_data});
                    state         <= S_WRITE;
                end
                S_WRITE: begin
                    if ((k + K_ONE) == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= S_CSUM;
`else
                        bus.cpu_start <= 1'b1;
                        state         <= S_START;
`endif
                    end else begin
                        k     <= k + K_ONE;
                        state <= S_DAT_HI;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: if (bus.in_valid) begin
                    if (bus.in_data == csum) begin
                        bus.cpu_start <= 1'b1;
                        state         <= S_START;
                    end else begin
                        error    <= 1'b1;
                        err_code <= ERR_CSUM;
                        state    <= S_ERR;
                    end
                end
`endif
                S_START: state <= S_RUN;
                S_RUN: begin
                    if (hit) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (expired) begin
                        error    <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= S_ERR;
                    end
                end
                S_DONE, S_ERR: if (clear) begin
                    done     <= 1'b0;
                    error    <= 1'b0;
                    err_code <= ERR_NONE;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_program_loader.sv
// tb/tb_cpu_program_loader.sv - table-driven checks of the cpu program loader plus reset/reload/clear sequences
module tb_cpu_program_loader;
    localparam int ADDR_W      = 9;
    localparam int MAX_WORDS   = 256;
    localparam int TIMEOUT_CYC = 1024;
`ifdef LOADER_CHECKSUM_EN
    localparam int CS_OK = 1;
`else
    localparam int CS_OK = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;
    logic busy, done, error;
    logic [1:0] err_code;
    logic [ADDR_W:0] retired;

    always #5 clk = ~clk;

    cpu_program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(16)) bus ();

    cpu_program_loader #(
        .ADDR_W(ADDR_W), .DATA_W(16), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .retired(retired)
    );

    typedef struct {
        string       name;
        logic [15:0] len;
        int          nw;
        bit          bub;
        bit          gen;
        int          cs;
        bit          e_done;
        bit          e_err;
        logic [1:0]  e_code;
        int          e_ret;
        int          e_writes;
        int          e_starts;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] prog[8];
    int          n_checks = 0;
    int          n_fail = 0;
    int          drop_cnt = 0;

    // ADD, SUB, MUL, DIV, STORE, LOAD, ADD, STORE
    initial prog = '{16'h1012, 16'h2301, 16'h3123, 16'h4230, 16'h5007, 16'h6107, 16'h1312, 16'h5308};

    // cpu model: 3 cycles low then 1 cycle high on cpu_ready while enabled
    bit gen_en = 1'b0;
    int phase = 0;
    always @(negedge clk) begin
        if (gen_en) begin
            phase = (phase == 3) ? 0 : phase + 1;
            bus.cpu_ready = (phase == 3);
        end else begin
            phase = 0;
            bus.cpu_ready = 1'b0;
        end
    end

    logic [8:0]  wl_addr[$];
    logic [15:0] wl_data[$];
    int          tot_starts = 0;
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wl_addr.push_back(bus.mem_addr);
            wl_data.push_back(bus.mem_wdata);
        end
        if (bus.cpu_start === 1'b1) tot_starts++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bub);
        bit ok = 1'b0;
        if (bub) repeat ($urandom_range(0, 2)) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (bus.in_ready) ok = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!ok) drop_cnt++;
    endtask

    task automatic run_stream(input logic [15:0] len, input int nw, input bit bub, input int cs);
        logic [7:0] x;
        x = len[15:8] ^ len[7:0];
        send_byte(len[15:8], bub);
        send_byte(len[7:0], bub);
        for (int i = 0; i < nw; i++) begin
            send_byte(prog[i][15:8], bub);
            send_byte(prog[i][7:0], bub);
            x = x ^ prog[i][15:8] ^ prog[i][7:0];
        end
        if (cs == 1) send_byte(x, bub);
        if (cs == 2) send_byte(x ^ 8'h04, bub);
    endtask

    task automatic wait_end(output int t_start, output int t_end);
        t_start = -1;
        t_end   = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.cpu_start === 1'b1 && t_start < 0) t_start = c;
            if (done === 1'b1 || error === 1'b1) begin
                t_end = c;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wb, sb, ts, te, bad, nwr;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        vecs.push_back('{"load8",     16'd8,   8, 1'b0, 1'b1, CS_OK, 1'b1, 1'b0, 2'b00, 8, 8, 1});
        vecs.push_back('{"load8_bub", 16'd8,   8, 1'b1, 1'b1, CS_OK, 1'b1, 1'b0, 2'b00, 8, 8, 1});
        vecs.push_back('{"len0",      16'd0,   0, 1'b0, 1'b1, 0,     1'b0, 1'b1, 2'b01, 0, 0, 0});
        vecs.push_back('{"len257",    16'd257, 0, 1'b0, 1'b1, 0,     1'b0, 1'b1, 2'b01, 0, 0, 0});
        vecs.push_back('{"timeout",   16'd2,   2, 1'b0, 1'b0, CS_OK, 1'b0, 1'b1, 2'b10, 0, 2, 1});
`ifdef LOADER_CHECKSUM_EN
        vecs.push_back('{"csum_bad",  16'd8,   8, 1'b0, 1'b1, 2,     1'b0, 1'b1, 2'b11, 0, 8, 0});
`endif

        do_reset();
        check("rst_outputs", {busy, done, error, err_code, retired, bus.mem_we, bus.mem_addr,
                              bus.mem_wdata, bus.cpu_start}, 0);
        check("rst_in_ready", bus.in_ready, 1);

        foreach (vecs[v]) begin
            do_reset();
            gen_en = vecs[v].gen;
            wb = wl_addr.size();
            sb = tot_starts;
            run_stream(vecs[v].len, vecs[v].nw, vecs[v].bub, vecs[v].cs);
            wait_end(ts, te);
            check({vecs[v].name, "_finished"}, te >= 0, 1);
            check({vecs[v].name, "_done"}, done, vecs[v].e_done);
            check({vecs[v].name, "_error"}, error, vecs[v].e_err);
            check({vecs[v].name, "_err_code"}, err_code, vecs[v].e_code);
            check({vecs[v].name, "_retired"}, retired, vecs[v].e_ret);
            check({vecs[v].name, "_busy"}, busy, 0);
            nwr = wl_addr.size() - wb;
            check({vecs[v].name, "_writes"}, nwr, vecs[v].e_writes);
            check({vecs[v].name, "_starts"}, tot_starts - sb, vecs[v].e_starts);
            if (vecs[v].e_writes > 0) begin
                bad = 0;
                for (int i = 0; i < nwr && i < 8; i++)
                    if (wl_addr[wb + i] !== 9'(i) || wl_data[wb + i] !== prog[i]) bad++;
                check({vecs[v].name, "_write_seq"}, bad, 0);
            end
            if (vecs[v].e_code == 2'b10)
                check("timeout_latency_in_window",
                      (te - ts >= TIMEOUT_CYC) && (te - ts <= TIMEOUT_CYC + 4), 1);
        end

        // Reset asserted after three words have been written
        do_reset();
        gen_en = 1'b0;
        wb = wl_addr.size();
        send_byte(8'h00, 1'b0);
        send_byte(8'h08, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_byte(prog[i][15:8], 1'b0);
            send_byte(prog[i][7:0], 1'b0);
        end
        #2;
        check("midload_writes", wl_addr.size() - wb, 3);
        check("midload_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("midload_rst_outputs", {busy, done, error, err_code, retired, bus.mem_we, bus.mem_addr,
                                      bus.mem_wdata, bus.cpu_start}, 0);

        // Reload N=1 straight out of the mid-load reset
        @(negedge clk);
        reset = 1'b1;
        gen_en = 1'b1;
        wb = wl_addr.size();
        send_byte(8'h00, 1'b0);
        check("reload_busy_after_first_byte", busy, 1);
        send_byte(8'h01, 1'b0);
        send_byte(prog[0][15:8], 1'b0);
        send_byte(prog[0][7:0], 1'b0);
        if (CS_OK == 1) send_byte(8'h01 ^ prog[0][15:8] ^ prog[0][7:0], 1'b0);
        wait_end(ts, te);
        check("reload_done", done, 1);
        check("reload_retired", retired, 1);
        check("reload_write", {wl_addr.size() - wb, wl_addr[wb], wl_data[wb]},
              {32'd1, 9'd0, prog[0]});

        // Extra ready edges after DONE are ignored, then clear returns to idle
        repeat (10) @(negedge clk);
        check("done_retired_holds", retired, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_flags", {done, error, err_code, busy}, 0);
        check("clear_in_ready", bus.in_ready, 1);

        check("stream_bytes_accepted", drop_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
